// File: rtl/alu_decoder_pkg.sv
// alu_decoder_pkg -- shared definitions for the decode stage and the execute ALU.
//
// Contents:
//   WORD_WIDTH       default datapath / instruction width
//   ALU_OP_WIDTH     width of the operator code sent to the execute ALU
//   ALU_*            operator codes understood by the execute ALU
//   OPC_*            RV32I major opcodes handled by the decoder
//   opa_sel_e        operand A source (zero, rs1, pc)
//   opb_sel_e        operand B source (zero, rs2, immediate)
//   buf_state_e      occupancy of the output/skid buffer
//   alu_op_from_funct3  maps funct3 (+ alternate bit) to an ALU operator
package alu_decoder_pkg;

  localparam int WORD_WIDTH   = 32;
  localparam int ALU_OP_WIDTH = 4;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL  = 4'd2;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLT  = 4'd3;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU = 4'd4;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR  = 4'd5;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL  = 4'd6;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA  = 4'd7;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OR   = 4'd8;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_AND  = 4'd9;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {OPA_ZERO, OPA_RS1, OPA_PC} opa_sel_e;
  typedef enum logic [1:0] {OPB_ZERO, OPB_RS2, OPB_IMM} opb_sel_e;
  typedef enum logic [1:0] {BUF_EMPTY, BUF_ONE, BUF_FULL} buf_state_e;

  // alt selects SUB over ADD and SRA over SRL; callers only set it where
  // funct7 is a real function field, never for an I-type immediate.
  function automatic logic [ALU_OP_WIDTH-1:0] alu_op_from_funct3(input logic [2:0] funct3,
                                                                input logic       alt);
    logic [ALU_OP_WIDTH-1:0] op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_decoder_instr_decode.sv
// alu_decoder_instr_decode -- purely combinational RV32I integer-ALU decoder.
//
// Ports:
//   instr_i     32-bit instruction word
//   operator_o  ALU operator (ALU_ADD for illegal encodings)
//   opa_sel_o   operand A source
//   opb_sel_o   operand B source
//   imm_o       immediate, already extended to WORD_WIDTH
//   rd_we_o     register write enable (legal and rd != x0)
//   illegal_o   encoding not supported
//
// Configuration: define ALU_DECODER_UPPER_IMM_EN to decode LUI and AUIPC;
// otherwise both are reported illegal.
module alu_decoder_instr_decode
  import alu_decoder_pkg::*;
#(
  parameter int WORD_WIDTH = alu_decoder_pkg::WORD_WIDTH
) (
  input  logic [31:0]             instr_i,
  output logic [ALU_OP_WIDTH-1:0] operator_o,
  output opa_sel_e                opa_sel_o,
  output opb_sel_e                opb_sel_o,
  output logic [WORD_WIDTH-1:0]   imm_o,
  output logic                    rd_we_o,
  output logic                    illegal_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       legal;

  // rs1 is routed to the register file directly by the top level.
  logic unused_rs1_field;
  assign unused_rs1_field = ^instr_i[19:15];

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  always_comb begin
    operator_o = ALU_ADD;
    opa_sel_o  = OPA_ZERO;
    opb_sel_o  = OPB_ZERO;
    imm_o      = '0;
    legal      = 1'b0;

    case (opcode)
      OPC_OP: begin
        // Only SUB and SRA have an alternate-funct7 form.
        if ((funct7 == FUNCT7_BASE) ||
            ((funct7 == FUNCT7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)))) begin
          legal      = 1'b1;
          operator_o = alu_op_from_funct3(funct3, funct7[5]);
          opa_sel_o  = OPA_RS1;
          opb_sel_o  = OPB_RS2;
        end
      end
      OPC_OP_IMM: begin
        if (funct3 == 3'b001) begin
          legal = (funct7 == FUNCT7_BASE);
          imm_o = WORD_WIDTH'(instr_i[24:20]);
        end else if (funct3 == 3'b101) begin
          legal = (funct7 == FUNCT7_BASE) || (funct7 == FUNCT7_ALT);
          imm_o = WORD_WIDTH'(instr_i[24:20]);
        end else begin
          legal = 1'b1;
          imm_o = WORD_WIDTH'($signed(instr_i[31:20]));
        end
        if (legal) begin
          // Bit 30 is immediate data except for the right-shift form.
          operator_o = alu_op_from_funct3(funct3, funct7[5] && (funct3 == 3'b101));
          opa_sel_o  = OPA_RS1;
          opb_sel_o  = OPB_IMM;
        end else begin
          imm_o = '0;
        end
      end
`ifdef ALU_DECODER_UPPER_IMM_EN
      OPC_LUI: begin
        legal     = 1'b1;
        opa_sel_o = OPA_ZERO;
        opb_sel_o = OPB_IMM;
        imm_o     = WORD_WIDTH'($signed({instr_i[31:12], 12'b0}));
      end
      OPC_AUIPC: begin
        legal     = 1'b1;
        opa_sel_o = OPA_PC;
        opb_sel_o = OPB_IMM;
        imm_o     = WORD_WIDTH'($signed({instr_i[31:12], 12'b0}));
      end
`endif
      default: ;
    endcase

    illegal_o = !legal;
    rd_we_o   = legal && (instr_i[11:7] != 5'd0);
  end

endmodule

// File: rtl/alu_decoder.sv
// alu_decoder -- decode stage between fetch and the integer execute unit.
// Decodes RV32I OP / OP-IMM instructions, captures register operands at
// acceptance and buffers results in an output register plus one skid
// register so instr_ready_o can be a flop.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   instr_i, instr_pc_i             instruction and its PC
//   instr_valid_i / instr_ready_o   fetch-side handshake (ready registered)
//   rs1_addr_o, rs2_addr_o          register-file read addresses (combinational)
//   rs1_rdata_i, rs2_rdata_i        same-cycle register-file read data
//   ex_valid_o / ex_ready_i         execute-side handshake
//   ex_operator_o, ex_operand_a_o, ex_operand_b_o, ex_rd_addr_o,
//   ex_rd_we_o, ex_illegal_o        decoded payload
//
// Configuration: define ALU_DECODER_UPPER_IMM_EN to add LUI and AUIPC
// (AUIPC uses instr_pc_i as operand A); undefined, both decode illegal.
module alu_decoder
  import alu_decoder_pkg::*;
#(
  parameter int WORD_WIDTH     = alu_decoder_pkg::WORD_WIDTH,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WORD_WIDTH-1:0]     instr_i,
  input  logic [WORD_WIDTH-1:0]     instr_pc_i,
  input  logic                      instr_valid_i,
  output logic                      instr_ready_o,
  output logic [REG_ADDR_WIDTH-1:0] rs1_addr_o,
  output logic [REG_ADDR_WIDTH-1:0] rs2_addr_o,
  input  logic [WORD_WIDTH-1:0]     rs1_rdata_i,
  input  logic [WORD_WIDTH-1:0]     rs2_rdata_i,
  output logic                      ex_valid_o,
  input  logic                      ex_ready_i,
  output logic [ALU_OP_WIDTH-1:0]   ex_operator_o,
  output logic [WORD_WIDTH-1:0]     ex_operand_a_o,
  output logic [WORD_WIDTH-1:0]     ex_operand_b_o,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd_addr_o,
  output logic                      ex_rd_we_o,
  output logic                      ex_illegal_o
);

  typedef struct packed {
    logic [ALU_OP_WIDTH-1:0]   op;
    logic [WORD_WIDTH-1:0]     a;
    logic [WORD_WIDTH-1:0]     b;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      we;
    logic                      ill;
  } payload_t;

  logic [ALU_OP_WIDTH-1:0] dec_operator;
  opa_sel_e                dec_opa_sel;
  opb_sel_e                dec_opb_sel;
  logic [WORD_WIDTH-1:0]   dec_imm;
  logic                    dec_rd_we;
  logic                    dec_illegal;

  payload_t   new_payload;
  payload_t   out_d, out_q;
  payload_t   skid_d, skid_q;
  buf_state_e state_d, state_q;
  logic       instr_ready_d, instr_ready_q;
  logic       ex_valid;
  logic       accept;
  logic       drain;

  assign rs1_addr_o = REG_ADDR_WIDTH'(instr_i[19:15]);
  assign rs2_addr_o = REG_ADDR_WIDTH'(instr_i[24:20]);

  alu_decoder_instr_decode #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_instr_decode (
    .instr_i    (instr_i[31:0]),
    .operator_o (dec_operator),
    .opa_sel_o  (dec_opa_sel),
    .opb_sel_o  (dec_opb_sel),
    .imm_o      (dec_imm),
    .rd_we_o    (dec_rd_we),
    .illegal_o  (dec_illegal)
  );

`ifndef ALU_DECODER_UPPER_IMM_EN
  logic unused_pc;
  assign unused_pc = ^instr_pc_i;
`endif

  // Operands are sampled here, in the accept cycle; nothing is forwarded.
  always_comb begin
    new_payload     = '0;
    new_payload.op  = dec_operator;
    new_payload.rd  = REG_ADDR_WIDTH'(instr_i[11:7]);
    new_payload.we  = dec_rd_we;
    new_payload.ill = dec_illegal;
    case (dec_opa_sel)
      OPA_RS1: new_payload.a = rs1_rdata_i;
`ifdef ALU_DECODER_UPPER_IMM_EN
      OPA_PC:  new_payload.a = instr_pc_i;
`endif
      default: new_payload.a = '0;
    endcase
    case (dec_opb_sel)
      OPB_RS2: new_payload.b = rs2_rdata_i;
      OPB_IMM: new_payload.b = dec_imm;
      default: new_payload.b = '0;
    endcase
  end

  assign ex_valid = (state_q != BUF_EMPTY);
  assign accept   = instr_valid_i && instr_ready_q;
  assign drain    = ex_valid && ex_ready_i;

  // Accept is impossible in FULL because instr_ready_q is low there.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      BUF_EMPTY: begin
        if (accept) begin
          out_d   = new_payload;
          state_d = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (accept && drain) begin
          out_d = new_payload;
        end else if (accept) begin
          skid_d  = new_payload;
          state_d = BUF_FULL;
        end else if (drain) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        if (drain) begin
          out_d   = skid_q;
          state_d = BUF_ONE;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
    instr_ready_d = (state_d != BUF_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BUF_EMPTY;
      instr_ready_q <= 1'b1;
      out_q         <= '0;
      out_q.op      <= ALU_ADD;
      skid_q        <= '0;
      skid_q.op     <= ALU_ADD;
    end else begin
      state_q       <= state_d;
      instr_ready_q <= instr_ready_d;
      out_q         <= out_d;
      skid_q        <= skid_d;
    end
  end

  assign instr_ready_o  = instr_ready_q;
  assign ex_valid_o     = ex_valid;
  assign ex_operator_o  = out_q.op;
  assign ex_operand_a_o = out_q.a;
  assign ex_operand_b_o = out_q.b;
  assign ex_rd_addr_o   = out_q.rd;
  assign ex_rd_we_o     = out_q.we;
  assign ex_illegal_o   = out_q.ill;

endmodule

// File: tb/tb_alu_decoder.sv
// Testbench for alu_decoder: directed vector table, back-pressure and reset
// sequences, then random traffic checked against a queue-based reference.
module tb_alu_decoder;
  import alu_decoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr_i = '0, instr_pc_i = '0, rs1_rdata_i = '0, rs2_rdata_i = '0;
  logic        instr_valid_i = 1'b0, ex_ready_i = 1'b0;
  logic        instr_ready_o, ex_valid_o, ex_rd_we_o, ex_illegal_o;
  logic [4:0]  rs1_addr_o, rs2_addr_o, ex_rd_addr_o;
  logic [3:0]  ex_operator_o;
  logic [31:0] ex_operand_a_o, ex_operand_b_o;

  always #5 clk = ~clk;

  alu_decoder #(.WORD_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_i(instr_i), .instr_pc_i(instr_pc_i),
    .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
    .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
    .rs1_rdata_i(rs1_rdata_i), .rs2_rdata_i(rs2_rdata_i),
    .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
    .ex_operator_o(ex_operator_o), .ex_operand_a_o(ex_operand_a_o),
    .ex_operand_b_o(ex_operand_b_o), .ex_rd_addr_o(ex_rd_addr_o),
    .ex_rd_we_o(ex_rd_we_o), .ex_illegal_o(ex_illegal_o)
  );

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] pc;
    exp_t        exp;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  exp_t model_q[$];  // entries held by the decoder, oldest first
  vec_t vecs[11];

  function automatic exp_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] rd, input logic we, input logic ill);
    exp_t e;
    e.op = op; e.a = a; e.b = b; e.rd = rd; e.we = we; e.ill = ill;
    return e;
  endfunction

  // Reference decode straight from the RV32I integer-ALU rules.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] r1,
                                      input logic [31:0] r2, input logic [31:0] pc);
    logic [3:0]  base_ops[8];
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic        legal;
    exp_t        e;
    base_ops = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    legal = 1'b0;
    e = mk(ALU_ADD, 32'd0, 32'd0, ins[11:7], 1'b0, 1'b0);
    if (opc == 7'h33) begin
      e.a = r1; e.b = r2; e.op = base_ops[f3];
      if (f7 == 7'h00) legal = 1'b1;
      else if (f7 == 7'h20 && f3 == 3'd0) begin legal = 1'b1; e.op = ALU_SUB; end
      else if (f7 == 7'h20 && f3 == 3'd5) begin legal = 1'b1; e.op = ALU_SRA; end
    end else if (opc == 7'h13) begin
      e.a = r1; e.op = base_ops[f3];
      if (f3 == 3'd1 || f3 == 3'd5) begin
        e.b = {27'd0, ins[24:20]};
        legal = (f7 == 7'h00) || (f3 == 3'd5 && f7 == 7'h20);
        if (f3 == 3'd5 && f7 == 7'h20) e.op = ALU_SRA;
      end else begin
        e.b = {{20{ins[31]}}, ins[31:20]};
        legal = 1'b1;
      end
    end
`ifdef ALU_DECODER_UPPER_IMM_EN
    else if (opc == 7'h37 || opc == 7'h17) begin
      legal = 1'b1;
      e.op  = ALU_ADD;
      e.a   = (opc == 7'h17) ? pc : 32'd0;
      e.b   = {ins[31:12], 12'd0};
    end
`endif
    if (!legal) begin
      e.op = ALU_ADD; e.a = 32'd0; e.b = 32'd0;
    end
    e.ill = !legal;
    e.we  = legal && (ins[11:7] != 5'd0);
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [6:0]  f7;
    int          sel;
    ins = $urandom;
    case ($urandom_range(0, 3))
      0, 1:    f7 = 7'h00;
      2:       f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    sel = $urandom_range(0, 5);
    if (sel <= 1)      begin ins[6:0] = 7'h33; ins[31:25] = f7; end
    else if (sel <= 3) begin ins[6:0] = 7'h13; ins[31:25] = f7; end
    else if (sel == 4) ins[6:0] = ($urandom_range(0, 1) == 0) ? 7'h37 : 7'h17;
    return ins;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic check_payload(input string tag, input exp_t e);
    check({tag, " operator"}, 64'(ex_operator_o), 64'(e.op));
    check({tag, " operand_a"}, 64'(ex_operand_a_o), 64'(e.a));
    check({tag, " operand_b"}, 64'(ex_operand_b_o), 64'(e.b));
    check({tag, " rd_addr"}, 64'(ex_rd_addr_o), 64'(e.rd));
    check({tag, " rd_we"}, 64'(ex_rd_we_o), 64'(e.we));
    check({tag, " illegal"}, 64'(ex_illegal_o), 64'(e.ill));
  endtask

  task automatic check_outputs(input string tag);
    check({tag, " instr_ready"}, 64'(instr_ready_o), 64'(model_q.size() < 2));
    check({tag, " ex_valid"}, 64'(ex_valid_o), 64'(model_q.size() > 0));
    if (model_q.size() > 0) check_payload({tag, " model"}, model_q[0]);
  endtask

  // Called at a falling edge: drive, advance one rising edge, update the
  // reference, then compare at the next falling edge.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [31:0] pc, input logic rdy,
                       input string tag);
    logic acc, drn;
    instr_valid_i = v; instr_i = ins; rs1_rdata_i = r1; rs2_rdata_i = r2;
    instr_pc_i = pc; ex_ready_i = rdy;
    #1;
    check({tag, " rs1_addr"}, 64'(rs1_addr_o), 64'(ins[19:15]));
    check({tag, " rs2_addr"}, 64'(rs2_addr_o), 64'(ins[24:20]));
    @(posedge clk);
    acc = v && (model_q.size() < 2);
    drn = (model_q.size() > 0) && rdy;
    if (drn) void'(model_q.pop_front());
    if (acc) model_q.push_back(ref_decode(ins, r1, r2, pc));
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic idle(input logic rdy, input string tag);
    cycle(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, rdy, tag);
  endtask

  initial begin
    vecs[0]  = '{32'h002081B3, 32'd5, 32'd7, 32'h0, mk(ALU_ADD, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0)};
    vecs[1]  = '{32'hFFF00293, 32'd0, 32'd9, 32'h0, mk(ALU_ADD, 32'd0, 32'hFFFFFFFF, 5'd5, 1'b1, 1'b0)};
    vecs[2]  = '{32'h4030D093, 32'h80000000, 32'd1, 32'h0, mk(ALU_SRA, 32'h80000000, 32'd3, 5'd1, 1'b1, 1'b0)};
    vecs[3]  = '{32'h00000000, 32'h1234, 32'h5678, 32'h0, mk(ALU_ADD, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1)};
    vecs[4]  = '{32'h402081B3, 32'd10, 32'd3, 32'h0, mk(ALU_SUB, 32'd10, 32'd3, 5'd3, 1'b1, 1'b0)};
    vecs[5]  = '{32'h022081B3, 32'd10, 32'd3, 32'h0, mk(ALU_ADD, 32'd0, 32'd0, 5'd3, 1'b0, 1'b1)};
    vecs[6]  = '{32'h40309093, 32'd4, 32'd0, 32'h0, mk(ALU_ADD, 32'd0, 32'd0, 5'd1, 1'b0, 1'b1)};
    vecs[7]  = '{32'h0F00F013, 32'hFF, 32'd0, 32'h0, mk(ALU_AND, 32'hFF, 32'hF0, 5'd0, 1'b0, 1'b0)};
    vecs[8]  = '{32'hFFB13393, 32'd6, 32'd0, 32'h0, mk(ALU_SLTU, 32'd6, 32'hFFFFFFFB, 5'd7, 1'b1, 1'b0)};
`ifdef ALU_DECODER_UPPER_IMM_EN
    vecs[9]  = '{32'h123452B7, 32'd77, 32'd0, 32'h40, mk(ALU_ADD, 32'd0, 32'h12345000, 5'd5, 1'b1, 1'b0)};
    vecs[10] = '{32'hABCDE317, 32'd77, 32'd0, 32'h1000, mk(ALU_ADD, 32'h1000, 32'hABCDE000, 5'd6, 1'b1, 1'b0)};
`else
    vecs[9]  = '{32'h123452B7, 32'd77, 32'd0, 32'h40, mk(ALU_ADD, 32'd0, 32'd0, 5'd5, 1'b0, 1'b1)};
    vecs[10] = '{32'hABCDE317, 32'd77, 32'd0, 32'h1000, mk(ALU_ADD, 32'd0, 32'd0, 5'd6, 1'b0, 1'b1)};
`endif

    // Reset state
    repeat (2) @(negedge clk);
    check("reset ex_valid", 64'(ex_valid_o), 64'd0);
    check("reset instr_ready", 64'(instr_ready_o), 64'd1);
    check_payload("reset", mk(ALU_ADD, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0));
    rst_n = 1'b1;
    idle(1'b1, "post-reset");

    // Directed vectors, back to back with the execute side always ready
    for (int i = 0; i < 11; i++) begin
      cycle(1'b1, vecs[i].instr, vecs[i].r1, vecs[i].r2, vecs[i].pc, 1'b1, $sformatf("vec%0d", i));
      check($sformatf("vec%0d ex_valid", i), 64'(ex_valid_o), 64'd1);
      check_payload($sformatf("vec%0d table", i), vecs[i].exp);
    end
    idle(1'b1, "vec drain");
    check("vec drain ex_valid", 64'(ex_valid_o), 64'd0);

    // Back-pressure: three offered, two accepted, then drained in order
    cycle(1'b1, 32'h00100093, 32'd0, 32'd0, 32'd0, 1'b0, "bp A");
    cycle(1'b1, 32'h00200113, 32'd0, 32'd0, 32'd0, 1'b0, "bp B");
    check("bp full ready", 64'(instr_ready_o), 64'd0);
    cycle(1'b1, 32'h00300193, 32'd0, 32'd0, 32'd0, 1'b0, "bp C");
    check("bp refused ready", 64'(instr_ready_o), 64'd0);
    check("bp stable rd", 64'(ex_rd_addr_o), 64'd1);
    check("bp stable b", 64'(ex_operand_b_o), 64'd1);
    idle(1'b1, "bp drain1");
    check("bp second rd", 64'(ex_rd_addr_o), 64'd2);
    check("bp second b", 64'(ex_operand_b_o), 64'd2);
    check("bp ready back", 64'(instr_ready_o), 64'd1);
    idle(1'b1, "bp drain2");
    check("bp empty", 64'(ex_valid_o), 64'd0);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom, $urandom,
            $urandom_range(0, 2) != 0, "rand");
    end

    // Reset in the middle of a full buffer
    while (model_q.size() > 0) idle(1'b1, "pre-reset drain");
    cycle(1'b1, rand_instr(), $urandom, $urandom, $urandom, 1'b0, "mid fill1");
    cycle(1'b1, rand_instr(), $urandom, $urandom, $urandom, 1'b0, "mid fill2");
    instr_valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    model_q.delete();
    check("mid-reset ex_valid", 64'(ex_valid_o), 64'd0);
    check("mid-reset instr_ready", 64'(instr_ready_o), 64'd1);
    check_payload("mid-reset", mk(ALU_ADD, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) idle(1'b1, "after reset");

    for (int n = 0; n < 300; n++) begin
      cycle($urandom_range(0, 1) != 0, rand_instr(), $urandom, $urandom, $urandom,
            $urandom_range(0, 3) != 0, "rand2");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
